// File: rtl/frame_deser_pkg.sv
// Shared types and parity constants for the frame deserializer.
package frame_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Odd parity expects the inverse of the data XOR.
    function automatic logic expected_parity(input logic data_xor, input logic par_typ);
        logic exp_bit;
        if (par_typ == PAR_ODD) begin
            exp_bit = ~data_xor;
        end else begin
            exp_bit = data_xor;
        end
        return exp_bit;
    endfunction

endpackage

// File: rtl/frame_parity_check.sv
// Compares a received parity bit against the parity expected for a data word.
module frame_parity_check
    import frame_deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_bit,
    input  logic                  i_par_typ,
    output logic                  o_err
);

    function automatic logic data_parity(input logic [DATA_WIDTH-1:0] data);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            acc = acc ^ data[i];
        end
        return acc;
    endfunction

    logic w_expected;

    // Expected parity and mismatch flag.
    always_comb begin
        w_expected = expected_parity(data_parity(i_data), i_par_typ);
        o_err      = (i_par_bit != w_expected);
    end

endmodule

// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame deserializer with optional parity and a one-word
// output holding register guarded by an overrun flag.
module frame_deserializer
    import frame_deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_deser_en,
    input  logic                  i_sampled_bit,
    input  logic                  i_msb_first,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    input  logic                  i_ready,
    input  logic                  i_ovr_clr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_par_err,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_e                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
    logic                  r_msb_first, w_msb_first_nxt;
    logic                  r_par_en, w_par_en_nxt;
    logic                  r_par_typ, w_par_typ_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_par_err, w_par_err_nxt;
    logic                  r_overrun, w_overrun_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  w_done, w_done_err, w_par_mismatch, w_ovr_set;
    logic [DATA_WIDTH-1:0] w_done_data;

    frame_parity_check #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (r_shift),
        .i_par_bit (i_sampled_bit),
        .i_par_typ (r_par_typ),
        .o_err     (w_par_mismatch)
    );

    // Shift register value after accepting the current sampled bit.
    always_comb begin
        if (r_msb_first) begin
            w_shifted = {r_shift[DATA_WIDTH-2:0], i_sampled_bit};
        end else begin
            w_shifted = {i_sampled_bit, r_shift[DATA_WIDTH-1:1]};
        end
    end

    // Frame sequencing: next state, counter, shifter and word completion.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_msb_first_nxt = r_msb_first;
        w_par_en_nxt    = r_par_en;
        w_par_typ_nxt   = r_par_typ;
        w_done          = 1'b0;
        w_done_data     = r_shift;
        w_done_err      = 1'b0;
        if (i_start) begin
            // A start strobe always wins, including over a coincident data strobe.
            w_state_nxt     = ST_SHIFT;
            w_cnt_nxt       = CNT_ZERO;
            w_shift_nxt     = {DATA_WIDTH{1'b0}};
            w_msb_first_nxt = i_msb_first;
            w_par_en_nxt    = i_par_en;
            w_par_typ_nxt   = i_par_typ;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (i_deser_en) begin
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                        if (r_cnt == CNT_LAST) begin
                            if (r_par_en) begin
                                w_state_nxt = ST_PARITY;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_done      = 1'b1;
                                w_done_data = w_shifted;
                            end
                        end else begin
                            w_state_nxt = ST_SHIFT;
                        end
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_PARITY: begin
                    if (i_deser_en) begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                        w_done_data = r_shift;
                        w_done_err  = w_par_mismatch;
                    end else begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Output holding register, handshake and sticky overrun.
    always_comb begin
        w_data_nxt    = r_data;
        w_par_err_nxt = r_par_err;
        w_valid_nxt   = r_valid;
        w_ovr_set     = 1'b0;
        if (w_done) begin
            if (!r_valid || i_ready) begin
                w_data_nxt    = w_done_data;
                w_par_err_nxt = w_done_err;
                w_valid_nxt   = 1'b1;
            end else begin
                w_ovr_set = 1'b1;
            end
        end else if (r_valid && i_ready) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_valid;
        end
        if (w_ovr_set) begin
            w_overrun_nxt = 1'b1;
        end else if (i_ovr_clr) begin
            w_overrun_nxt = 1'b0;
        end else begin
            w_overrun_nxt = r_overrun;
        end
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_shift     <= {DATA_WIDTH{1'b0}};
            r_msb_first <= 1'b0;
            r_par_en    <= 1'b0;
            r_par_typ   <= PAR_EVEN;
            r_data      <= {DATA_WIDTH{1'b0}};
            r_valid     <= 1'b0;
            r_par_err   <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_msb_first <= w_msb_first_nxt;
            r_par_en    <= w_par_en_nxt;
            r_par_typ   <= w_par_typ_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_par_err   <= w_par_err_nxt;
            r_overrun   <= w_overrun_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_par_err = r_par_err;
    assign o_overrun = r_overrun;
    assign o_busy    = r_busy;

endmodule
